// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction RAM with valid/ready fetch pipeline, flush and fault reporting
module imem_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 1024,
    parameter logic [31:0]      BASE_ADDR = 32'h0000_0000,
    parameter int               REG_OUT   = 0,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_instr,
    output logic [31:0]              resp_addr,
    output logic [1:0]               resp_fault,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data,
    output logic [31:0]              fetch_cnt
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [XLEN-1:0] mem [DEPTH];

    logic            advance;
    logic            accept;
    logic [31:0]     offset;
    logic [1:0]      dec_fault;
    logic [AW-1:0]   dec_idx;
    logic [XLEN-1:0] rd_word;

    logic            src_valid;
    logic [31:0]     src_addr;
    logic [1:0]      src_fault;
    logic [XLEN-1:0] src_instr;

    assign advance   = !resp_valid || resp_ready;
    assign req_ready = advance && !ld_we && !rst;
    assign accept    = req_valid && req_ready;

    // Offset wraps, so addresses below BASE_ADDR land far out of range.
    assign offset  = req_addr - BASE_ADDR;
    assign dec_idx = offset[AW+1:2];

    always_comb begin
        dec_fault = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            dec_fault = 2'b01;
        end else if ({1'b0, offset} >= SPAN) begin
            dec_fault = 2'b10;
        end
    end

    // Read is captured into a register at acceptance; faults never index the RAM.
    assign rd_word = (dec_fault == 2'b00) ? mem[dec_idx] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    if (REG_OUT != 0) begin : g_s1
        logic            s1_valid;
        logic [31:0]     s1_addr;
        logic [1:0]      s1_fault;
        logic [XLEN-1:0] s1_instr;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_addr  <= '0;
                s1_fault <= 2'b00;
                s1_instr <= '0;
            end else begin
                if (advance) begin
                    s1_valid <= accept;
                    if (accept) begin
                        s1_addr  <= req_addr;
                        s1_fault <= dec_fault;
                        s1_instr <= rd_word;
                    end
                end
                if (flush) begin
                    s1_valid <= accept;
                end
            end
        end

        assign src_valid = s1_valid;
        assign src_addr  = s1_addr;
        assign src_fault = s1_fault;
        assign src_instr = s1_instr;
    end else begin : g_direct
        assign src_valid = accept;
        assign src_addr  = req_addr;
        assign src_fault = dec_fault;
        assign src_instr = rd_word;
    end

    // Only the redirect target survives a flush, and it only reaches the output directly without S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_instr <= '0;
            resp_addr  <= '0;
            resp_fault <= 2'b00;
            fetch_cnt  <= '0;
        end else begin
            if (resp_valid && resp_ready) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (advance) begin
                resp_valid <= src_valid;
                if (src_valid) begin
                    resp_instr <= src_instr;
                    resp_addr  <= src_addr;
                    resp_fault <= src_fault;
                end
            end
            if (flush) begin
                resp_valid <= (REG_OUT == 0) && accept;
            end
        end
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised successor to the combinational instruction memory. It holds a word-addressed instruction RAM with a program-load write port, a synchronous read path, and a valid/ready request/response handshake toward the fetch stage. Configurable latency (1 or 2 cycles), stall hold, branch flush and address fault reporting. Sits between the PC/fetch logic and the IF/ID register of the RV32I pipeline.

Parameters:
XLEN, 32, instruction/data width in bits
DEPTH, 1024, number of words (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0
REG_OUT, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
NOP_INSTR, 32'h0000_0013, word returned on fault (ADDI x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  fetch request present
req_ready  out  1  request accepted this cycle when req_valid&&req_ready
req_addr  in  32  byte address of requested instruction
flush  in  1  kill all in-flight requests (branch/jump redirect)
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response (low = stall)
resp_instr  out  XLEN  instruction word
resp_addr  out  32  byte address the response belongs to
resp_fault  out  2  00 ok, 01 misaligned, 10 out of range
ld_we  in  1  program-load write strobe
ld_addr  in  log2(DEPTH)  word index for load write
ld_data  in  XLEN  word to write
fetch_cnt  out  32  count of completed responses

Behaviour:
- Reset (rst=1 at edge): all pipeline valids cleared, resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=00, fetch_cnt=0. Memory contents NOT cleared. Reset mid-transaction drops every in-flight request, with no response produced.
- Pipeline: REG_OUT=0 has one stage (the output register). REG_OUT=1 has stage S1 (RAM read) plus the output register.
- advance = !resp_valid || resp_ready. All stages move together only when advance=1; otherwise everything holds. resp_* must stay stable while resp_valid && !resp_ready.
- req_ready = advance && !ld_we && !rst. Combinational, with no dependency on req_valid.
- Latency: a request accepted at edge N with no stall gives resp_valid at edge N+1 (REG_OUT=0) or N+2 (REG_OUT=1). Back-to-back throughput is one per cycle.
- Address decode on acceptance:
  - offset = req_addr - BASE_ADDR (32-bit wrap).
  - req_addr[1:0] != 0 -> fault 01.
  - else offset >= DEPTH*4 -> fault 10 (also covers addresses below BASE via wrap).
  - else index = offset[log2(DEPTH)+1:2].
  - Misaligned has priority over out of range.
  - Faulted responses return resp_instr=NOP_INSTR and carry the original req_addr. The RAM is not read for them.
- Load port: when ld_we=1, mem[ld_addr] <= ld_data at the edge. req_ready is forced 0 in that cycle. In-flight responses already read are not updated. The next accepted request sees the new data.
- Flush: at an edge with flush=1, all in-flight valids (S1 and output) are cleared, even if stalled. A request accepted in the same cycle (req_valid && req_ready, with advance evaluated pre-flush) is the redirect target and is kept. flush && rst behaves as rst.
- fetch_cnt increments by 1 on every edge where resp_valid && resp_ready, wraps 2^32-1 -> 0, and is unaffected by flush.
- RAM has one read port and one write port. The read uses the index registered at acceptance. Reads are synchronous, with no combinational path from req_addr to resp_instr.

Test Plan:
- Preload mem[0..3] = 000002B3, 00000333, 00628863, 002083B3 via ld_we; REG_OUT=0; request addrs 0,4,8,12 back-to-back with resp_ready=1 -> responses on consecutive cycles, one cycle after each acceptance, matching words in order; fetch_cnt=4.
- REG_OUT=1, same stream; hold resp_ready=0 for 3 cycles after first response -> req_ready=0 during stall, resp_instr=000002B3 stable, no loss/duplication, all 4 delivered, 2-cycle latency.
- Issue addr 0,4; assert flush together with req_valid at addr 0x14 -> in-flight 0/4 responses never appear; next response is mem[5] with resp_addr=0x14.
- req_addr=0x6 -> fault 01, instr 00000013. req_addr=0x1000 with DEPTH=1024 -> fault 10, instr 00000013. BASE_ADDR=0x100, req_addr=0x0 -> fault 10.
- ld_we=1 writing mem[6]=0052A303 while req_valid=1 -> req_ready=0 that cycle; next fetch of 0x18 returns 0052A303.
- Assert rst for 1 cycle with 2 requests in flight and fetch_cnt=7 -> resp_valid=0, fetch_cnt=0 next cycle, memory preserved (re-fetch of 0x0 returns 000002B3).
